// File: rtl/hilo_mult_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: op codes, FSM states
// and op-classification helpers.
package hilo_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MADD  = 3'b011;
  localparam logic [2:0] OP_MSUB  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  function automatic logic OP_IS_SIGNED(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic OP_ACCUM(input logic [2:0] op);
    return (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic OP_IS_MUL(input logic [2:0] op);
    return (op == OP_MULTU) || OP_IS_SIGNED(op);
  endfunction

endpackage

// File: rtl/hilo_mult_sequencer_mult_step.sv
// One combinational shift-add step: adds the multiplicand, shifted by each
// set multiplier bit position, into the 64-bit partial product.
module mult_step #(
  parameter int BITS = 2
) (
  input  logic [63:0]     i_prod,
  input  logic [63:0]     i_mcand,
  input  logic [BITS-1:0] i_bits,
  output logic [63:0]     o_prod
);

  logic [63:0] w_sum;

  always_comb begin
    w_sum = i_prod;
    for (int j = 0; j < BITS; j++) begin
      if (i_bits[j]) w_sum = w_sum + (i_mcand << j);
    end
  end

  assign o_prod = w_sum;

endmodule

// File: rtl/hilo_mult_sequencer.sv
// Multi-cycle multiply/accumulate engine owning the architectural HI/LO pair;
// iterative unsigned shift-add on operand magnitudes, sign applied at commit.
module hilo_mult_sequencer
  import hilo_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ReqValid,
  input  logic [2:0]  ReqOp,
  input  logic [31:0] ReqA,
  input  logic [31:0] ReqB,
  output logic        ReqReady,
  input  logic        Flush,
  input  logic        HiLoRead,
  output logic        Stall,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int N = 32 / BITS_PER_CYCLE;

  state_t      r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;
  logic [5:0]  r_cnt;
  logic [2:0]  r_op;
  logic        r_sign;
  logic [63:0] r_prod;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;

  logic        w_accept;
  logic [31:0] w_magA;
  logic [31:0] w_magB;
  logic        w_sign;
  logic [63:0] w_stepProd;
  logic [63:0] w_product;
  logic [63:0] w_commit;

  assign ReqReady = (r_state == S_IDLE);
  assign w_accept = ReqValid & ReqReady & ~Flush;
  assign Busy     = r_busy;
  assign Done     = r_done;
  assign Stall    = HiLoRead & r_busy;
  assign Hi       = r_hi;
  assign Lo       = r_lo;

  // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
  always_comb begin
    w_magA = (OP_IS_SIGNED(ReqOp) && ReqA[31]) ? -ReqA : ReqA;
    w_magB = (OP_IS_SIGNED(ReqOp) && ReqB[31]) ? -ReqB : ReqB;
    w_sign = OP_IS_SIGNED(ReqOp) & (ReqA[31] ^ ReqB[31]);
  end

  mult_step #(.BITS(BITS_PER_CYCLE)) u_step (
    .i_prod  (r_prod),
    .i_mcand (r_mcand),
    .i_bits  (r_mplier[BITS_PER_CYCLE-1:0]),
    .o_prod  (w_stepProd)
  );

  always_comb begin
    w_product = r_sign ? -r_prod : r_prod;
    w_commit  = w_product;
    if (r_op == OP_MADD)      w_commit = {r_hi, r_lo} + w_product;
    else if (r_op == OP_MSUB) w_commit = {r_hi, r_lo} - w_product;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= S_IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_op     <= OP_NOP;
      r_sign   <= 1'b0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (ReqOp == OP_MTHI) begin
              r_hi <= ReqA;
            end else if (ReqOp == OP_MTLO) begin
              r_lo <= ReqA;
            end else if (OP_IS_MUL(ReqOp)) begin
              r_state  <= S_RUN;
              r_busy   <= 1'b1;
              r_op     <= ReqOp;
              r_sign   <= w_sign;
              r_prod   <= '0;
              r_mcand  <= {32'd0, w_magA};
              r_mplier <= w_magB;
              r_cnt    <= '0;
            end
          end
        end
        S_RUN: begin
          if (Flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_prod   <= w_stepProd;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            r_cnt    <= r_cnt + 6'd1;
            if (r_cnt == 6'(N - 1)) r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!Flush) begin
            {r_hi, r_lo} <= w_commit;
            r_done       <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
